// File: rtl/pe_pad_ctrl_if.sv
// Pad-controller bus: layer-tile configuration handshake, data-flow qualifiers,
// and the pad/weight-pad control bundle driven back by the sequencer.
interface pe_pad_ctrl_if #(
  parameter int ConfDWd  = 32'd4,
  parameter int PConfDWd = 32'd3,
  parameter int RowCntWd = 32'd8
);
  logic                i_cfg_valid;
  logic                o_cfg_ready;
  logic [ConfDWd-1:0]  i_cfg_IFLen;
  logic [ConfDWd-1:0]  i_cfg_PopU;
  logic [PConfDWd-1:0] i_cfg_Pch;
  logic [RowCntWd-1:0] i_cfg_nRow;
  logic                i_ipix_valid;
  logic                i_au_ready;
  logic                i_flush;
  logic [ConfDWd-1:0]  o_cont_IFLen;
  logic [ConfDWd-1:0]  o_cont_PopU;
  logic [PConfDWd-1:0] o_cont_Pch;
  logic                o_cont_start;
  logic                o_cont_pop;
  logic                o_cont_nxtRow;
  logic                o_cont_lastPix;
  logic                o_cont_stall;
  logic                o_cont_reset;
  logic                o_cont_done;
  logic                o_cont_swapWt;
  logic                o_busy;

  modport master (
    output i_cfg_valid, i_cfg_IFLen, i_cfg_PopU, i_cfg_Pch, i_cfg_nRow,
    output i_ipix_valid, i_au_ready, i_flush,
    input  o_cfg_ready, o_cont_IFLen, o_cont_PopU, o_cont_Pch,
    input  o_cont_start, o_cont_pop, o_cont_nxtRow, o_cont_lastPix,
    input  o_cont_stall, o_cont_reset, o_cont_done, o_cont_swapWt, o_busy
  );

  modport slave (
    input  i_cfg_valid, i_cfg_IFLen, i_cfg_PopU, i_cfg_Pch, i_cfg_nRow,
    input  i_ipix_valid, i_au_ready, i_flush,
    output o_cfg_ready, o_cont_IFLen, o_cont_PopU, o_cont_Pch,
    output o_cont_start, o_cont_pop, o_cont_nxtRow, o_cont_lastPix,
    output o_cont_stall, o_cont_reset, o_cont_done, o_cont_swapWt, o_busy
  );
endinterface

// File: rtl/pe_pad_ctrl.sv
// Per-PE IF-pad / weight-pad sequencer: load a pixel window, stream it to the AU,
// slide by PopU pixels, repeat for every output position.
module pe_pad_ctrl #(
  parameter int ConfDWd  = 32'd4,
  parameter int PConfDWd = 32'd3,
  parameter int RowCntWd = 32'd8
) (
  input logic          i_clk,
  input logic          i_rstn,
  pe_pad_ctrl_if.slave bus
);
  localparam int CntWd = ConfDWd + PConfDWd;
  localparam logic [CntWd-1:0]    CNT_ONE  = {{(CntWd-1){1'b0}}, 1'b1};
  localparam logic [CntWd-1:0]    CNT_ZERO = {CntWd{1'b0}};
  localparam logic [ConfDWd-1:0]  CFG_ONE  = {{(ConfDWd-1){1'b0}}, 1'b1};
  localparam logic [ConfDWd-1:0]  CFG_ZERO = {ConfDWd{1'b0}};
  localparam logic [PConfDWd-1:0] PCH_ONE  = {{(PConfDWd-1){1'b0}}, 1'b1};
  localparam logic [PConfDWd-1:0] PCH_ZERO = {PConfDWd{1'b0}};
  localparam logic [RowCntWd-1:0] ROW_ONE  = {{(RowCntWd-1){1'b0}}, 1'b1};
  localparam logic [RowCntWd-1:0] ROW_ZERO = {RowCntWd{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e              state_r, state_nxt_s;
  logic [ConfDWd-1:0]  ifl_r, popu_r, ifl_cfg_s, popu_cfg_s;
  logic [PConfDWd-1:0] pch_r, ch_cnt_r;
  logic [RowCntWd-1:0] nrow_r, row_cnt_r;
  logic [ConfDWd-1:0]  pix_cnt_r;
  logic [CntWd-1:0]    word_cnt_r, w_s, n_s, p_s, fill_last_s;
  logic                first_r;
  logic                accept_s, flush_s, fill_ok_s, fill_end_s, compute_ok_s;
  logic                last_pix_s, last_row_s;

  // Clamp incoming configuration: IFLen 0 runs as 1, PopU never exceeds the window.
  always_comb begin
    if (bus.i_cfg_IFLen == CFG_ZERO) ifl_cfg_s = CFG_ONE;
    else                             ifl_cfg_s = bus.i_cfg_IFLen;
    if (bus.i_cfg_PopU > ifl_cfg_s)  popu_cfg_s = ifl_cfg_s;
    else                             popu_cfg_s = bus.i_cfg_PopU;
  end

  assign w_s = CntWd'(pch_r) + CNT_ONE;
  assign n_s = CntWd'(ifl_r) * w_s;
  assign p_s = CntWd'(popu_r) * w_s;

  // Per-cycle event decode shared by the FSM, counters and outputs.
  always_comb begin
    accept_s     = (state_r == S_IDLE) && bus.i_cfg_valid;
    flush_s      = (state_r != S_IDLE) && bus.i_flush;
    fill_ok_s    = ((state_r == S_LOAD) || (state_r == S_ADVANCE)) && bus.i_ipix_valid;
    compute_ok_s = (state_r == S_COMPUTE) && bus.i_au_ready;
    last_pix_s   = (state_r == S_COMPUTE) && (pix_cnt_r == (ifl_r - CFG_ONE)) && (ch_cnt_r == pch_r);
    last_row_s   = (row_cnt_r == nrow_r);
    if (state_r == S_LOAD) fill_last_s = n_s - CNT_ONE;
    else                   fill_last_s = p_s - CNT_ONE;
    fill_end_s   = (word_cnt_r == fill_last_s);
  end

  // Configuration latch, held until the next accept.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ifl_r  <= CFG_ZERO;
      popu_r <= CFG_ZERO;
      pch_r  <= PCH_ZERO;
      nrow_r <= ROW_ZERO;
    end else if (accept_s) begin
      ifl_r  <= ifl_cfg_s;
      popu_r <= popu_cfg_s;
      pch_r  <= bus.i_cfg_Pch;
      nrow_r <= bus.i_cfg_nRow;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_r <= S_IDLE;
    else         state_r <= state_nxt_s;
  end

  // FSM next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:    if (accept_s) state_nxt_s = S_INIT; else state_nxt_s = S_IDLE;
      S_INIT:    state_nxt_s = S_LOAD;
      S_LOAD, S_ADVANCE: begin
        if (fill_ok_s && fill_end_s) state_nxt_s = S_COMPUTE;
        else                         state_nxt_s = state_r;
      end
      S_COMPUTE: begin
        if (compute_ok_s && last_pix_s) begin
          if (last_row_s)             state_nxt_s = S_DONE;
          else if (popu_r == CFG_ZERO) state_nxt_s = S_COMPUTE;
          else                        state_nxt_s = S_ADVANCE;
        end else begin
          state_nxt_s = S_COMPUTE;
        end
      end
      S_DONE:    state_nxt_s = S_IDLE;
      default:   state_nxt_s = S_IDLE;
    endcase
    if (flush_s) state_nxt_s = S_IDLE;
    else         state_nxt_s = state_nxt_s;
  end

  // Word / channel / pixel / row counters; all hold on stalled cycles.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      word_cnt_r <= CNT_ZERO;
      ch_cnt_r   <= PCH_ZERO;
      pix_cnt_r  <= CFG_ZERO;
      row_cnt_r  <= ROW_ZERO;
    end else if (flush_s || (state_r == S_INIT)) begin
      word_cnt_r <= CNT_ZERO;
      ch_cnt_r   <= PCH_ZERO;
      pix_cnt_r  <= CFG_ZERO;
      row_cnt_r  <= ROW_ZERO;
    end else if (fill_ok_s) begin
      if (fill_end_s) begin
        word_cnt_r <= CNT_ZERO;
        pix_cnt_r  <= CFG_ZERO;
      end else begin
        word_cnt_r <= word_cnt_r + CNT_ONE;
      end
    end else if (compute_ok_s) begin
      if (ch_cnt_r == pch_r) begin
        ch_cnt_r <= PCH_ZERO;
        if (last_pix_s) begin
          pix_cnt_r <= CFG_ZERO;
          if (!last_row_s) row_cnt_r <= row_cnt_r + ROW_ONE;
        end else begin
          pix_cnt_r <= pix_cnt_r + CFG_ONE;
        end
      end else begin
        ch_cnt_r <= ch_cnt_r + PCH_ONE;
      end
    end
  end

  // Marks the first LOAD cycle so start pulses once even if that cycle stalls.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                 first_r <= 1'b0;
    else if (state_r == S_INIT)  first_r <= 1'b1;
    else if (state_r == S_LOAD)  first_r <= 1'b0;
  end

  assign bus.o_cont_IFLen = ifl_r;
  assign bus.o_cont_PopU  = popu_r;
  assign bus.o_cont_Pch   = pch_r;

  // FSM output decode; stall/pop follow the live data-flow qualifiers.
  always_comb begin
    bus.o_cfg_ready    = 1'b0;
    bus.o_busy         = 1'b1;
    bus.o_cont_start   = 1'b0;
    bus.o_cont_pop     = 1'b0;
    bus.o_cont_stall   = 1'b0;
    bus.o_cont_swapWt  = 1'b0;
    bus.o_cont_done    = 1'b0;
    bus.o_cont_lastPix = last_pix_s;
    bus.o_cont_nxtRow  = last_pix_s && !last_row_s;
    bus.o_cont_reset   = flush_s;
    case (state_r)
      S_IDLE: begin
        bus.o_cfg_ready = 1'b1;
        bus.o_busy      = 1'b0;
      end
      S_INIT: begin
        bus.o_cont_reset  = 1'b1;
        bus.o_cont_swapWt = 1'b1;
      end
      S_LOAD, S_ADVANCE: begin
        bus.o_cont_start = (state_r == S_LOAD) && first_r;
        bus.o_cont_pop   = bus.i_ipix_valid;
        bus.o_cont_stall = !bus.i_ipix_valid;
      end
      S_COMPUTE: bus.o_cont_stall = !bus.i_au_ready;
      S_DONE:    bus.o_cont_done  = 1'b1;
      default:   bus.o_busy       = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_pe_pad_ctrl.sv
// Directed bench for pe_pad_ctrl: cycle-counted sequences with hand-computed
// expectations for timing, strobe counts, clamping, stalls, flush and reset.
module tb_pe_pad_ctrl;
  logic i_clk = 1'b0;
  logic i_rstn;
  always #5 i_clk = ~i_clk;

  pe_pad_ctrl_if bus ();
  pe_pad_ctrl dut (.i_clk(i_clk), .i_rstn(i_rstn), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_cyc, start_cyc, done_cyc, n_pop, n_last, n_next, n_stall, t_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    acc_cyc = -1; start_cyc = -1; done_cyc = -1;
    n_pop = 0; n_last = 0; n_next = 0; n_stall = 0;
  endtask

  task automatic set_cfg(input logic [3:0] ifl, input logic [3:0] popu,
                         input logic [2:0] pch, input logic [7:0] nrow);
    bus.i_cfg_IFLen = ifl;
    bus.i_cfg_PopU  = popu;
    bus.i_cfg_Pch   = pch;
    bus.i_cfg_nRow  = nrow;
  endtask

  // One clock cycle: drive inputs just after the edge, sample just after that.
  task automatic run_cycle(input logic cv, input logic iv, input logic ar, input logic fl);
    @(posedge i_clk);
    #1;
    bus.i_cfg_valid  = cv;
    bus.i_ipix_valid = iv;
    bus.i_au_ready   = ar;
    bus.i_flush      = fl;
    #1;
    cyc++;
    if (cv && bus.o_cfg_ready) acc_cyc = cyc;
    if (bus.o_cont_start)   start_cyc = cyc;
    if (bus.o_cont_done)    done_cyc  = cyc;
    if (bus.o_cont_pop)     n_pop++;
    if (bus.o_cont_lastPix) n_last++;
    if (bus.o_cont_nxtRow)  n_next++;
    if (bus.o_cont_stall)   n_stall++;
  endtask

  task automatic run_to_done(input int budget, input logic iv, input logic ar);
    for (int k = 0; k < budget && done_cyc < 0; k++) run_cycle(1'b0, iv, ar, 1'b0);
  endtask

  initial begin
    bus.i_cfg_valid = 1'b0; bus.i_ipix_valid = 1'b0; bus.i_au_ready = 1'b0; bus.i_flush = 1'b0;
    set_cfg(4'd0, 4'd0, 3'd0, 8'd0);
    i_rstn = 1'b0;
    #12;
    check("rst_cfg_ready", bus.o_cfg_ready, 32'd1);
    check("rst_busy", bus.o_busy, 32'd0);
    check("rst_IFLen", bus.o_cont_IFLen, 32'd0);
    check("rst_strobes", {bus.o_cont_start, bus.o_cont_reset, bus.o_cont_swapWt,
                          bus.o_cont_done, bus.o_cont_stall, bus.o_cont_pop}, 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Baseline: IFLen=3 Pch=1 PopU=1 nRow=2, N=6 P=2
    set_cfg(4'd3, 4'd1, 3'd1, 8'd2); clr();
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("A_init_reset_swap", {bus.o_cont_reset, bus.o_cont_swapWt}, 32'd3);
    run_to_done(60, 1'b1, 1'b1);
    check("A_start_lat", start_cyc - acc_cyc, 32'd2);
    check("A_done_lat", done_cyc - acc_cyc, 32'd30);
    check("A_lastpix", n_last, 32'd3);
    check("A_nxtrow", n_next, 32'd2);
    check("A_pops", n_pop, 32'd10);
    check("A_stalls", n_stall, 32'd0);
    check("A_cfg", {bus.o_cont_IFLen, bus.o_cont_PopU, bus.o_cont_Pch}, {21'd0, 4'd3, 4'd1, 3'd1});
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("A_ready_after_done", {bus.o_cfg_ready, bus.o_busy}, 32'd2);

    // Same config, AU back-pressure for 4 cycles in the first COMPUTE
    clr();
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (9) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("B_stall_pop", {bus.o_cont_stall, bus.o_cont_pop}, 32'd2);
    run_to_done(60, 1'b1, 1'b1);
    check("B_stalls", n_stall, 32'd4);
    check("B_done_lat", done_cyc - acc_cyc, 32'd34);
    check("B_lastpix", n_last, 32'd3);
    check("B_pops", n_pop, 32'd10);

    // Starved LOAD: IFLen=2 Pch=0 nRow=0, valid pattern 1,0,1
    set_cfg(4'd2, 4'd1, 3'd0, 8'd0); clr();
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("C_init_no_stall", bus.o_cont_stall, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("C_starved", {bus.o_cont_stall, bus.o_cont_pop}, 32'd2);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("C_second_pop", bus.o_cont_pop, 32'd1);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("C_in_compute", {bus.o_cont_stall, bus.o_cont_pop}, 32'd0);
    run_to_done(20, 1'b1, 1'b1);
    check("C_pops", n_pop, 32'd2);
    check("C_done_lat", done_cyc - acc_cyc, 32'd7);
    check("C_nxtrow", n_next, 32'd0);

    // IFLen=0 runs as a 1-pixel window
    set_cfg(4'd0, 4'd0, 3'd0, 8'd0); clr();
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run_to_done(20, 1'b1, 1'b1);
    check("D_IFLen", bus.o_cont_IFLen, 32'd1);
    check("D_done_lat", done_cyc - acc_cyc, 32'd4);
    check("D_lastpix", n_last, 32'd1);

    // PopU=5 clamped to IFLen=3, Pch=1, nRow=1: N=6 P=6
    set_cfg(4'd3, 4'd5, 3'd1, 8'd1); clr();
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run_to_done(60, 1'b1, 1'b1);
    check("E_PopU", bus.o_cont_PopU, 32'd3);
    check("E_pops", n_pop, 32'd12);
    check("E_done_lat", done_cyc - acc_cyc, 32'd26);
    check("E_nxtrow", n_next, 32'd1);

    // Flush in the first ADVANCE cycle (T+14), new config the cycle after
    set_cfg(4'd3, 4'd1, 3'd1, 8'd2); clr();
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    t_flush = acc_cyc;
    repeat (13) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("F_flush_cycle", {bus.o_cont_reset, bus.o_cont_pop, bus.o_busy}, 32'd7);
    set_cfg(4'd2, 4'd1, 3'd0, 8'd3);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("F_idle", {bus.o_cfg_ready, bus.o_busy}, 32'd2);
    check("F_reaccept", acc_cyc - t_flush, 32'd15);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("F_init", {bus.o_cont_reset, bus.o_cont_swapWt, bus.o_busy}, 32'd7);

    // Async reset mid-COMPUTE (IFLen=2 Pch=0 nRow=3: lastPix on 2nd COMPUTE cycle)
    repeat (4) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("G_pre_lastpix", {bus.o_cont_lastPix, bus.o_cont_nxtRow}, 32'd3);
    #1;
    i_rstn = 1'b0;
    #1;
    check("G_rst_ready_busy", {bus.o_cfg_ready, bus.o_busy}, 32'd2);
    check("G_rst_strobes", {bus.o_cont_lastPix, bus.o_cont_nxtRow, bus.o_cont_start,
                            bus.o_cont_reset, bus.o_cont_swapWt, bus.o_cont_stall}, 32'd0);
    check("G_rst_cfg", {bus.o_cont_IFLen, bus.o_cont_Pch}, 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("G_after_release", {bus.o_cfg_ready, bus.o_busy}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_pad_ctrl.md
# pe_pad_ctrl

Per-PE sequencer for the input-feature scratchpad (IF pad) and the weight pad. It accepts one layer-tile configuration from the array controller and runs a fixed sequence:
- fill the IF pad with one window of pixels,
- read the window out to the AU,
- slide the window by PopU pixels,
- repeat for every output position.

It generates the pad's `cont` control bundle and `swapWt` for the weight pad. It stalls on input starvation or AU back-pressure.

## Interface
- ConfDWd, 4, width of IFLen/PopU fields
- PConfDWd, 3, width of Pch field
- RowCntWd, 8, width of output-position count

- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_cfg_valid  in  1  configuration valid
- o_cfg_ready  out  1  high only in IDLE
- i_cfg_IFLen  in  ConfDWd  window width in pixels; 0 is treated as 1
- i_cfg_PopU  in  ConfDWd  pixels popped per slide; values > IFLen are clamped to IFLen
- i_cfg_Pch  in  PConfDWd  words per pixel minus 1
- i_cfg_nRow  in  RowCntWd  output positions minus 1
- i_ipix_valid  in  1  IF buffer has a word for the pad
- i_au_ready  in  1  AU accepts the pad read word
- i_flush  in  1  synchronous abort
- o_cont_IFLen / o_cont_PopU / o_cont_Pch  out  ConfDWd/ConfDWd/PConfDWd  latched (clamped) configuration
- o_cont_start, o_cont_pop, o_cont_nxtRow, o_cont_lastPix, o_cont_stall, o_cont_reset, o_cont_done  out  1 each  pad control
- o_cont_swapWt  out  1  weight-pad bank swap
- o_busy  out  1  state != IDLE

## Operation
- Configuration is accepted on i_cfg_valid && o_cfg_ready. Accepted fields are latched into o_cont_* and held until the next accept.
- Derived counts, computed from the latched values:
  - W = Pch+1
  - N = IFLen·W, width ConfDWd+PConfDWd
  - P = PopU·W
- Counters, all advancing only on non-stalled cycles:
  - ch_cnt: 0..Pch
  - pix_cnt: 0..IFLen-1
  - row_cnt: 0..nRow
  - word_cnt: 0..N-1 or 0..P-1
- IDLE:
  - o_cfg_ready=1.
  - On accept, go to INIT.
- INIT (1 cycle):
  - o_cont_reset=1, o_cont_swapWt=1.
  - Clear all counters.
  - Go to LOAD.
- LOAD:
  - o_cont_start=1 on the first LOAD cycle only.
  - o_cont_pop=i_ipix_valid.
  - Stall when !i_ipix_valid.
  - After N accepted words, go to COMPUTE.
- COMPUTE:
  - Each non-stalled cycle is one pad read.
  - ch_cnt wraps at Pch and then increments pix_cnt.
  - Stall when !i_au_ready.
  - o_cont_lastPix=1 when pix_cnt==IFLen-1 && ch_cnt==Pch.
  - o_cont_nxtRow = lastPix && row_cnt!=nRow, asserted in the same cycle as lastPix.
  - On a non-stalled lastPix cycle:
    - if row_cnt==nRow, go to DONE;
    - else increment row_cnt and go to ADVANCE.
- ADVANCE:
  - Same pop/stall rules as LOAD.
  - After P accepted words, go to COMPUTE and clear pix_cnt.
- DONE (1 cycle):
  - o_cont_done=1.
  - Go to IDLE.
- o_cont_stall:
  - = (COMPUTE && !i_au_ready) || ((LOAD||ADVANCE) && !i_ipix_valid).
  - Combinational, as is o_cont_pop.
  - 0 in IDLE, INIT and DONE.
- i_flush:
  - In any non-IDLE state, next state is IDLE and o_cont_reset=1 in the flush cycle.
  - Flush has priority over every transition, including DONE.
  - Ignored in IDLE.
- Reset values:
  - state=IDLE, all counters 0.
  - All o_cont_* strobes 0, o_busy=0, o_cfg_ready=1.
  - Latched configuration fields = 0.
- Simultaneous events:
  - A stall on a lastPix cycle holds lastPix/nxtRow asserted until the cycle completes.
  - A config arriving while busy is not accepted and waits.

## Timing
- Accept at cycle T.
- INIT at T+1.
- First LOAD cycle (start=1) at T+2.
- With no stalls, DONE is at T+2+N+(nRow+1)·N+nRow·P.
- Each stall cycle adds exactly one cycle.
- o_cfg_ready returns to 1 the cycle after DONE; back-to-back configurations are therefore spaced by DONE+1.
- Strobes are Moore-decoded from registered state/counters, except stall/pop, which are combinational on i_ipix_valid/i_au_ready.

## Test plan
- IFLen=3, Pch=1, PopU=1, nRow=2, no stalls:
  - start at T+2;
  - 3 lastPix pulses;
  - 2 nxtRow pulses;
  - done at T+30;
  - pop count = 6+2·2 = 10.
- Same configuration with i_au_ready low for 4 cycles mid-COMPUTE:
  - stall=1 for exactly those 4 cycles;
  - counters frozen;
  - done at T+34.
- i_ipix_valid toggling 1/0 during LOAD with IFLen=2, Pch=0:
  - pop only on valid cycles;
  - COMPUTE entered after the 2nd accepted word.
- Edge configurations:
  - IFLen=0 → runs as IFLen=1.
  - PopU=5 with IFLen=3 → o_cont_PopU=3, ADVANCE lasts 3·W cycles.
  - nRow=0 → no nxtRow, no ADVANCE.
- i_flush in ADVANCE:
  - next cycle IDLE, o_cont_reset=1 in the flush cycle;
  - a new configuration is accepted the cycle after.
- i_rstn asserted mid-COMPUTE:
  - all outputs return to reset values asynchronously;
  - o_cfg_ready=1 after release.
